// File: rtl/uart_frame_loader_pkg.sv
// loader_pkg: shared state enum, pixel type and default parameters for the UART frame loader.
package loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ABORT} loader_state_t;
  typedef logic [23:0] pixel_t;
  localparam int DEF_PIXELS = 76800;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_TIMEOUT_CYC = 10_000_000;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_frame_loader_rgb_packer.sv
// rgb_packer: gathers three bytes into an {R,G,B} pixel; pixel_valid fires combinationally with the third byte.
module rgb_packer
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_strobe,
  input  logic [7:0] i_byte,
  output logic       o_valid,
  output pixel_t     o_pixel
);
  logic [1:0] r_idx;
  logic [7:0] r_r;
  logic [7:0] r_g;
  always_ff @(posedge clk)
    if (!i_rst_n || i_clr) begin
      r_idx <= '0;
      r_r   <= '0;
      r_g   <= '0;
    end else if (i_strobe) begin
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      if (r_idx == 2'd0) r_r <= i_byte;
      if (r_idx == 2'd1) r_g <= i_byte;
    end
  assign o_valid = i_strobe && r_idx == 2'd2;
  assign o_pixel = {r_r, r_g, i_byte};
endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: waits for a sync byte, packs UART bytes into RGB pixels and writes a full frame to BRAM port A.
module uart_frame_loader
  import loader_pkg::*;
#(
  parameter int         PIXELS      = DEF_PIXELS,
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  loader_state_t r_state, w_next;
  logic [ADDR_W-1:0] r_pix;
  logic [TO_W-1:0]   r_to;
  logic              r_wr_en, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_wr_addr;
  pixel_t            r_wr_data;
  logic              w_load, w_sync, w_to, w_pv, w_last;
  pixel_t            w_pix;
  assign w_load = r_state == LOAD;
  assign w_sync = r_state == IDLE && rx_ready && rx_data == SYNC_BYTE;
  assign w_to   = w_load && !rx_ready && (r_to + TO_W'(1)) == TO_W'(TIMEOUT_CYC - 1);
  assign w_last = w_pv && r_pix == ADDR_W'(PIXELS - 1);
  rgb_packer u_packer (
    .clk      (CLK100MHZ),
    .i_rst_n  (CPU_RESETN),
    .i_clr    (w_sync || w_to),
    .i_strobe (w_load && rx_ready),
    .i_byte   (rx_data),
    .o_valid  (w_pv),
    .o_pixel  (w_pix)
  );
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (w_sync ? LOAD : IDLE)
           : r_state == LOAD ? (w_last ? DONE : w_to ? ABORT : LOAD)
           : IDLE;
  end
  // done/err pulses trail their state by one cycle so frame_done lands after the last wr_en
  always_ff @(posedge CLK100MHZ)
    if (!CPU_RESETN) begin
      r_state   <= IDLE;
      r_pix     <= '0;
      r_to      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pix   <= w_sync ? '0 : w_pv ? r_pix + ADDR_W'(1) : r_pix;
      r_to    <= (w_sync || rx_ready) ? '0 : w_load ? r_to + TO_W'(1) : r_to;
      r_wr_en <= w_pv;
      if (w_pv) begin
        r_wr_addr <= r_pix;
        r_wr_data <= w_pix;
      end
      r_busy <= w_next != IDLE;
      r_done <= r_state == DONE;
      r_err  <= r_state == ABORT;
    end
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign frame_err  = r_err;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: random-byte frames checked against a byte-to-pixel reference with cycle-accurate write/done/err timing.
module tb_uart_frame_loader;
  localparam int PIX = 4;
  localparam int TO  = 50;
  localparam int AW  = 18;
  logic clk = 1'b0, rst_n = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic wr_en, busy, frame_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;
  int n_assert = 0, n_fail = 0, cyc = 0;
  int wq_cyc[$];
  logic [AW-1:0] wq_addr[$];
  logic [23:0] wq_data[$];
  int done_q[$], err_q[$];
  uart_frame_loader #(.PIXELS(PIX), .ADDR_W(AW), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk);
    #1;
    if (wr_en) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (frame_done) done_q.push_back(cyc);
    if (frame_err) err_q.push_back(cyc);
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, output int c);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
    c = cyc;
  endtask
  task automatic clear_q();
    wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); done_q.delete(); err_q.delete();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_err"}, frame_err, 0);
  endtask
  task automatic run_frame(input bit b2b, input bit inj);
    logic [7:0] b[PIX*3];
    int c[PIX*3];
    int cs;
    foreach (b[i]) b[i] = 8'($urandom);
    if (inj) begin b[3] = 8'hA5; b[4] = 8'h00; b[5] = 8'h00; end
    clear_q();
    send(8'hA5, cs);
    check("busy_after_sync", busy, 1);
    for (int i = 0; i < PIX*3; i++) begin
      if (!b2b) idle($urandom_range(0, 3));
      send(b[i], c[i]);
    end
    send(8'hA5, cs);
    idle(3);
    check("busy_after_done", busy, 0);
    check("n_writes", wq_addr.size(), PIX);
    for (int i = 0; i < PIX && i < wq_addr.size(); i++) begin
      check($sformatf("addr%0d", i), wq_addr[i], i);
      check($sformatf("data%0d", i), wq_data[i], {b[3*i], b[3*i+1], b[3*i+2]});
      check($sformatf("wr_cyc%0d", i), wq_cyc[i], c[3*i+2]);
    end
    check("n_done", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cyc", done_q[0], c[PIX*3-1] + 1);
    check("n_err", err_q.size(), 0);
  endtask
  task automatic run_timeout(input int nb);
    int last;
    clear_q();
    send(8'hA5, last);
    for (int k = 0; k < nb; k++) send(k == 0 ? 8'hFF : 8'hEE, last);
    idle(TO + 10);
    check("to_n_writes", wq_addr.size(), 0);
    check("to_n_err", err_q.size(), 1);
    if (err_q.size() > 0) check("to_err_cyc", err_q[0], last + TO);
    check("to_n_done", done_q.size(), 0);
    check("to_busy", busy, 0);
  endtask
  initial begin
    int c;
    logic [7:0] x;
    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);
    send(8'h11, c);
    idle(1);
    send(8'h22, c);
    for (int i = 0; i < 4; i++) begin
      do x = 8'($urandom); while (x == 8'hA5);
      send(x, c);
    end
    idle(2);
    check("idle_busy", busy, 0);
    check("idle_writes", wq_addr.size(), 0);
    run_frame(0, 1);
    run_frame(1, 0);
    run_timeout(2);
    run_frame(0, 0);
    run_timeout(0);
    clear_q();
    send(8'hA5, c);
    for (int i = 0; i < 5; i++) send(8'($urandom), c);
    rst_n = 1'b0;
    idle(1);
    check_zero("midreset");
    rst_n = 1'b1;
    idle(TO + 10);
    check("midreset_no_err", err_q.size(), 0);
    run_frame(1, 1);
    repeat (3) run_frame(1'($urandom_range(0, 1)), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
